// File: rtl/memory_port_arbiter.sv
// Shares the chipset's byte-wide RAM port between bus cycles, CGA video fetches and periodic refresh.
// Define MEMORY_ARBITER_VIDEO_EN to build the video port and bus/video round-robin fairness.
module memory_port_arbiter #(
  parameter int REFRESH_INTERVAL = 780
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic [19:0] address,
  input  logic [7:0]  bus_write_data,
  input  logic        memory_read_n,
  input  logic        memory_write_n,
  input  logic        ram_address_select_n,
  output logic [7:0]  bus_read_data,
  output logic        memory_access_ready,
  input  logic        video_request,
  input  logic [19:0] video_address,
  output logic        video_ack,
  output logic [7:0]  video_read_data,
  output logic        ram_request,
  output logic        ram_write,
  output logic        ram_refresh,
  output logic [19:0] ram_address,
  output logic [7:0]  ram_write_data,
  input  logic        ram_ack,
  input  logic [7:0]  ram_read_data,
  output logic        refresh_overrun
);
  localparam int CW = $clog2(REFRESH_INTERVAL);

`ifdef MEMORY_ARBITER_VIDEO_EN
  typedef enum logic [2:0] {IDLE, BUS, BUS_HOLD, REFRESH, VIDEO} state_t;
`else
  typedef enum logic [1:0] {IDLE, BUS, BUS_HOLD, REFRESH} state_t;
`endif

  state_t        state_reg, state_next;
  logic [CW-1:0] refresh_count_reg;
  logic          refresh_pending_reg;
  logic          refresh_wrap;
  logic          pending_clear;
  logic          bus_pend;
  logic          request_next, write_next, refresh_next;
  logic [19:0]   address_next;
  logic [7:0]    write_data_next, bus_rdata_next;
`ifdef MEMORY_ARBITER_VIDEO_EN
  logic          last_bus_reg, last_bus_next;
  logic          video_ack_next;
  logic [7:0]    video_data_next;
`endif

  assign bus_pend     = ~ram_address_select_n & (~memory_read_n | ~memory_write_n);
  assign refresh_wrap = (refresh_count_reg == CW'(REFRESH_INTERVAL - 1));
  // Ready is forced high while reset is held so a stalled CPU cycle is released at once.
  assign memory_access_ready = ~reset_n | ~(bus_pend & (state_reg != BUS_HOLD));

  always_comb begin
    state_next      = state_reg;
    request_next    = ram_request;
    write_next      = ram_write;
    refresh_next    = ram_refresh;
    address_next    = ram_address;
    write_data_next = ram_write_data;
    bus_rdata_next  = bus_read_data;
    pending_clear   = 1'b0;
`ifdef MEMORY_ARBITER_VIDEO_EN
    last_bus_next   = last_bus_reg;
    video_ack_next  = 1'b0;
    video_data_next = video_read_data;
`endif
    case (state_reg)
      IDLE: begin
        if (refresh_pending_reg) begin
          state_next      = REFRESH;
          request_next    = 1'b1;
          write_next      = 1'b0;
          refresh_next    = 1'b1;
          address_next    = '0;
          write_data_next = '0;
        end
`ifdef MEMORY_ARBITER_VIDEO_EN
        else if (video_request && (!bus_pend || last_bus_reg)) begin
          state_next      = VIDEO;
          request_next    = 1'b1;
          write_next      = 1'b0;
          refresh_next    = 1'b0;
          address_next    = video_address;
          write_data_next = '0;
          last_bus_next   = 1'b0;
        end
`endif
        else if (bus_pend) begin
          state_next      = BUS;
          request_next    = 1'b1;
          write_next      = ~memory_write_n;
          refresh_next    = 1'b0;
          address_next    = address;
          write_data_next = bus_write_data;
`ifdef MEMORY_ARBITER_VIDEO_EN
          last_bus_next   = 1'b1;
`endif
        end
      end
      BUS: begin
        if (ram_ack) begin
          state_next   = BUS_HOLD;
          request_next = 1'b0;
          // A read whose strobe already released is simply dropped.
          if (!ram_write && bus_pend) bus_rdata_next = ram_read_data;
        end
      end
      BUS_HOLD: begin
        if (!bus_pend) state_next = IDLE;
      end
      REFRESH: begin
        if (ram_ack) begin
          state_next    = IDLE;
          request_next  = 1'b0;
          refresh_next  = 1'b0;
          pending_clear = 1'b1;
        end
      end
`ifdef MEMORY_ARBITER_VIDEO_EN
      VIDEO: begin
        if (ram_ack) begin
          state_next      = IDLE;
          request_next    = 1'b0;
          video_ack_next  = 1'b1;
          video_data_next = ram_read_data;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_reg           <= IDLE;
      refresh_count_reg   <= '0;
      refresh_pending_reg <= 1'b0;
      refresh_overrun     <= 1'b0;
      ram_request         <= 1'b0;
      ram_write           <= 1'b0;
      ram_refresh         <= 1'b0;
      ram_address         <= '0;
      ram_write_data      <= '0;
      bus_read_data       <= '0;
    end else begin
      state_reg           <= state_next;
      refresh_count_reg   <= refresh_wrap ? '0 : refresh_count_reg + 1'b1;
      // A wrap sets pending even in the cycle a refresh completes.
      refresh_pending_reg <= refresh_wrap | (refresh_pending_reg & ~pending_clear);
      refresh_overrun     <= refresh_overrun | (refresh_wrap & refresh_pending_reg);
      ram_request         <= request_next;
      ram_write           <= write_next;
      ram_refresh         <= refresh_next;
      ram_address         <= address_next;
      ram_write_data      <= write_data_next;
      bus_read_data       <= bus_rdata_next;
    end
  end

`ifdef MEMORY_ARBITER_VIDEO_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      last_bus_reg    <= 1'b0;
      video_ack       <= 1'b0;
      video_read_data <= '0;
    end else begin
      last_bus_reg    <= last_bus_next;
      video_ack       <= video_ack_next;
      video_read_data <= video_data_next;
    end
  end
`else
  logic unused_video;
  assign unused_video    = &{1'b0, video_request, video_address};
  assign video_ack       = 1'b0;
  assign video_read_data = '0;
`endif

endmodule

// File: tb/tb_memory_port_arbiter.sv
// Randomized bench for memory_port_arbiter: a cycle-level ownership model checks every output each cycle,
// and directed scenarios pin grant order, latency, refresh priority, overrun and reset behaviour.
module tb_memory_port_arbiter;
  localparam int N = 16;
`ifdef MEMORY_ARBITER_VIDEO_EN
  localparam bit VEN = 1'b1;
`else
  localparam bit VEN = 1'b0;
`endif
  localparam int O_IDLE = 0, O_BUS = 1, O_HOLD = 2, O_VID = 3, O_REF = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic [19:0] address = '0;
  logic [7:0]  bus_write_data = '0;
  logic        memory_read_n = 1'b1;
  logic        memory_write_n = 1'b1;
  logic        ram_address_select_n = 1'b1;
  logic [7:0]  bus_read_data;
  logic        memory_access_ready;
  logic        video_request = 1'b0;
  logic [19:0] video_address = '0;
  logic        video_ack;
  logic [7:0]  video_read_data;
  logic        ram_request, ram_write, ram_refresh;
  logic [19:0] ram_address;
  logic [7:0]  ram_write_data;
  logic        ram_ack = 1'b0;
  logic [7:0]  ram_read_data = '0;
  logic        refresh_overrun;

  memory_port_arbiter #(.REFRESH_INTERVAL(N)) dut (
    .clock(clock), .reset_n(reset_n), .address(address), .bus_write_data(bus_write_data),
    .memory_read_n(memory_read_n), .memory_write_n(memory_write_n),
    .ram_address_select_n(ram_address_select_n), .bus_read_data(bus_read_data),
    .memory_access_ready(memory_access_ready), .video_request(video_request),
    .video_address(video_address), .video_ack(video_ack), .video_read_data(video_read_data),
    .ram_request(ram_request), .ram_write(ram_write), .ram_refresh(ram_refresh),
    .ram_address(ram_address), .ram_write_data(ram_write_data), .ram_ack(ram_ack),
    .ram_read_data(ram_read_data), .refresh_overrun(refresh_overrun)
  );

  always #5 clock = ~clock;

  int tests_run = 0;
  int tests_failed = 0;
  bit stall = 1'b0;
  int fixed_lat = -1;
  bit force_rd = 1'b0;
  logic [7:0] force_val = '0;
  int inject_req = 0;
  bit rand_done = 1'b0;
  logic [21:0] dut_grants[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] ram_fn(input logic [19:0] a);
    return a[7:0] + 8'h5A;
  endfunction

  function automatic bit bus_pend_now();
    return !ram_address_select_n && (!memory_read_n || !memory_write_n);
  endfunction

  // RAM controller stand-in: acks each request after a latency, optional stall and stray-ack injection.
  initial begin
    int wait_cnt;
    int inject_done;
    wait_cnt = 0;
    inject_done = 0;
    forever begin
      @(posedge clock); #2;
      if (ram_ack) begin
        ram_ack = 1'b0;
      end else if (inject_done != inject_req) begin
        inject_done = inject_req;
        ram_ack = 1'b1;
        ram_read_data = 8'hEE;
      end else if (ram_request && !stall) begin
        if (wait_cnt == 0) begin
          ram_ack = 1'b1;
          ram_read_data = force_rd ? force_val : ram_fn(ram_address);
          $display("[TB] ram txn addr=%05h wr=%0d rf=%0d wdata=%02h rdata=%02h", ram_address,
                   ram_write, ram_refresh, ram_write_data, ram_read_data);
        end else begin
          wait_cnt--;
        end
      end else if (!ram_request) begin
        wait_cnt = (fixed_lat >= 0) ? fixed_lat : int'($urandom_range(0, 3));
      end
    end
  end

  // Grant monitor: logs {write, refresh, address} at every rising ram_request.
  initial begin
    bit prev;
    prev = 1'b0;
    forever begin
      @(posedge clock); #1;
      if (!reset_n) prev = 1'b0;
      else begin
        if (ram_request && !prev) dut_grants.push_back({ram_write, ram_refresh, ram_address});
        prev = ram_request;
      end
    end
  end

  // Behavioural model: who owns the port, refresh timer from cycles since reset.
  int m_owner, m_age;
  bit m_pending, m_overrun, m_last_bus, m_req, m_write, m_rfsh, m_vack;
  logic [19:0] m_addr;
  logic [7:0] m_wdata, m_rdata, m_vdata;

  task automatic m_reset();
    m_owner = O_IDLE; m_age = 0; m_pending = 0; m_overrun = 0; m_last_bus = 0;
    m_req = 0; m_write = 0; m_rfsh = 0; m_vack = 0;
    m_addr = '0; m_wdata = '0; m_rdata = '0; m_vdata = '0;
  endtask

  task automatic m_step();
    bit bp, wrap, was_pending;
    bp = bus_pend_now();
    wrap = (m_age % N) == N - 1;
    m_age++;
    was_pending = m_pending;
    m_vack = 0;
    case (m_owner)
      O_IDLE: begin
        if (was_pending) begin
          m_owner = O_REF; m_req = 1; m_write = 0; m_rfsh = 1; m_addr = '0;
        end else if (VEN && video_request && (!bp || m_last_bus)) begin
          m_owner = O_VID; m_req = 1; m_write = 0; m_rfsh = 0; m_addr = video_address; m_last_bus = 0;
        end else if (bp) begin
          m_owner = O_BUS; m_req = 1; m_write = !memory_write_n; m_rfsh = 0;
          m_addr = address; m_wdata = bus_write_data; m_last_bus = 1;
        end
      end
      O_BUS: if (ram_ack) begin
        m_req = 0; m_owner = O_HOLD;
        if (!m_write && bp) m_rdata = ram_read_data;
      end
      O_HOLD: if (!bp) m_owner = O_IDLE;
      O_VID: if (ram_ack) begin
        m_req = 0; m_owner = O_IDLE; m_vack = 1; m_vdata = ram_read_data;
      end
      O_REF: if (ram_ack) begin
        m_req = 0; m_rfsh = 0; m_owner = O_IDLE; m_pending = 0;
      end
      default: ;
    endcase
    if (wrap) begin
      if (was_pending) m_overrun = 1;
      m_pending = 1;
    end
  endtask

  initial begin
    m_reset();
    forever begin
      @(posedge clock or negedge reset_n);
      if (!reset_n) m_reset();
      else m_step();
    end
  end

  // Compare process: mid-cycle, every cycle out of reset.
  initial begin
    forever begin
      @(negedge clock);
      if (reset_n) begin
        check("ram_request", ram_request, m_req);
        check("ready", memory_access_ready, !(bus_pend_now() && m_owner != O_HOLD));
        check("bus_read_data", bus_read_data, m_rdata);
        check("video_ack", video_ack, m_vack);
        check("video_read_data", video_read_data, m_vdata);
        check("refresh_overrun", refresh_overrun, m_overrun);
        if (m_req) begin
          check("ram_address", ram_address, m_addr);
          check("ram_write", ram_write, m_write);
          check("ram_refresh", ram_refresh, m_rfsh);
          if (m_write) check("ram_write_data", ram_write_data, m_wdata);
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish at %0t", $time);
    $fatal(1, "watchdog timeout");
  end

  task automatic do_reset();
    reset_n = 1'b0;
    memory_read_n = 1'b1; memory_write_n = 1'b1; ram_address_select_n = 1'b1;
    video_request = 1'b0;
    repeat (2) begin @(posedge clock); #2; end
    reset_n = 1'b1;
  endtask

  // Caller is aligned 2 time units after a rising edge; one idle cycle follows the access.
  task automatic bus_access(input logic [19:0] a, input bit wr, input logic [7:0] d, input bit sel,
                            output int cycles);
    address = a; bus_write_data = d; ram_address_select_n = !sel;
    memory_read_n = wr; memory_write_n = !wr;
    cycles = 0;
    do begin @(posedge clock); #2; cycles++; end while (!memory_access_ready && cycles < 300);
    check("bus_done", memory_access_ready, 1);
    memory_read_n = 1'b1; memory_write_n = 1'b1; ram_address_select_n = 1'b1;
    @(posedge clock); #2;
  endtask

  task automatic video_fetch(input logic [19:0] a);
    int n;
    video_address = a; video_request = 1'b1; n = 0;
    do begin @(posedge clock); #2; n++; end while (!video_ack && n < (VEN ? 300 : 20));
    check("video_ack_seen", video_ack, VEN);
    if (video_ack) check("video_data", video_read_data, ram_fn(a));
    video_request = 1'b0;
  endtask

  initial begin
    int cyc, g0, n;
    logic [21:0] nonref[$];
    fixed_lat = 2; force_rd = 1'b1; force_val = 8'hA5;

    // Reset values
    repeat (2) begin @(posedge clock); #2; end
    check("rst_ram_request", ram_request, 0);
    check("rst_ready", memory_access_ready, 1);
    check("rst_bus_read_data", bus_read_data, 0);
    check("rst_video_ack", video_ack, 0);
    check("rst_overrun", refresh_overrun, 0);
    check("rst_ram_address", ram_address, 0);
    reset_n = 1'b1;

    // Directed bus read: ack 3 cycles after request, data A5
    g0 = dut_grants.size();
    bus_access(20'h12345, 1'b0, 8'h00, 1'b1, cyc);
    check("rd_latency", cyc, 4);
    check("rd_data", bus_read_data, 8'hA5);
    check("rd_grant_count", dut_grants.size() - g0, 1);
    check("rd_grant", dut_grants[g0], 22'h012345);
    force_rd = 1'b0; fixed_lat = -1;

    // Contention: bus and video both held, alternating grants
    do_reset();
    g0 = dut_grants.size();
    fork
      begin
        int c;
        for (int i = 0; i < 3; i++) bus_access(20'h11111, 1'b0, 8'h00, 1'b1, c);
      end
      begin
        for (int i = 0; i < 3; i++) video_fetch(20'h22222);
      end
    join
    nonref.delete();
    for (int i = g0; i < dut_grants.size(); i++)
      if (!dut_grants[i][20]) nonref.push_back(dut_grants[i]);
    check("cont_count", nonref.size() >= 3, 1);
    check("cont_g0", nonref[0], 22'h011111);
    check("cont_g1", nonref[1], VEN ? 22'h022222 : 22'h011111);
    check("cont_g2", nonref[2], 22'h011111);

    // Refresh priority: bus arrives just as the first wrap sets refresh pending
    do_reset();
    g0 = dut_grants.size();
    repeat (16) begin @(posedge clock); #2; end
    bus_access(20'h0ABCD, 1'b1, 8'h3C, 1'b1, cyc);
    check("rf_count", dut_grants.size() - g0, 2);
    check("rf_first", dut_grants[g0], 22'h100000);
    check("rf_then_bus", dut_grants[g0 + 1], 22'h20ABCD);

    // Overrun: refresh stalled across a full interval
    do_reset();
    stall = 1'b1;
    n = 0;
    do begin @(posedge clock); #2; n++; end while (!(ram_request && ram_refresh) && n < 100);
    check("ov_refresh_granted", ram_request & ram_refresh, 1);
    check("ov_early", refresh_overrun, 0);
    repeat (20) begin @(posedge clock); #2; end
    check("ov_set", refresh_overrun, 1);
    stall = 1'b0;
    bus_access(20'h00F00, 1'b0, 8'h00, 1'b1, cyc);
    bus_access(20'h00F01, 1'b1, 8'h77, 1'b1, cyc);
    check("ov_sticky", refresh_overrun, 1);

    // Reset in the middle of a bus cycle, then a stray ack
    do_reset();
    stall = 1'b1;
    address = 20'h0F0F0; ram_address_select_n = 1'b0; memory_read_n = 1'b0;
    n = 0;
    do begin @(posedge clock); #2; n++; end while (!ram_request && n < 20);
    check("mid_bus_granted", ram_request, 1);
    #1 reset_n = 1'b0;
    #1;
    check("mid_rst_request", ram_request, 0);
    check("mid_rst_ready", memory_access_ready, 1);
    @(posedge clock); #2;
    memory_read_n = 1'b1; ram_address_select_n = 1'b1; stall = 1'b0;
    @(posedge clock); #2;
    reset_n = 1'b1;
    inject_req++;
    repeat (3) begin @(posedge clock); #2; end
    check("stray_request", ram_request, 0);
    check("stray_bus_data", bus_read_data, 0);
    check("stray_video_ack", video_ack, 0);

    // Randomized mixed traffic
    do_reset();
    rand_done = 1'b0;
    fork
      begin
        int c, idle;
        for (int i = 0; i < 150; i++) begin
          bus_access(20'($urandom), 1'($urandom_range(0, 1)), 8'($urandom),
                     $urandom_range(0, 7) != 0, c);
          idle = $urandom_range(0, 3);
          repeat (idle) begin @(posedge clock); #2; end
        end
        rand_done = 1'b1;
      end
      begin
        int idle;
        while (!rand_done) begin
          idle = $urandom_range(0, 6);
          repeat (idle) begin @(posedge clock); #2; end
          if (!rand_done) video_fetch(20'($urandom));
        end
      end
    join

    repeat (4) begin @(posedge clock); #2; end
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
